// File: rtl/vram_slot_seq.sv
// vram_slot_seq
// Time-multiplexed VRAM access sequencer. A frame is PLANES display-fetch
// slots (one per colour plane) followed by one CPU slot, each slot lasting
// PHASES clock cycles. Every slot drives registered RAS/CAS/WE/address-select
// strobes. The CPU slot is granted either only during blanking (MODE=0) or
// on every frame (MODE=1). Granted accesses complete with a one-cycle CPU_ACK.
//
// Ports:
//   CLK        system clock
//   RSTn       asynchronous active-low reset
//   BLANKn     1 = active display, 0 = blanking (sampled at phase 0 of a slot)
//   MODE       0 = CPU slot only during blanking, 1 = CPU slot always
//   CPU_REQ    level request, held until CPU_ACK
//   CPU_RW     1 = read, 0 = write
//   CPU_PLANE  plane mask for the CPU access
//   CPU_ACK    one-cycle pulse on the last phase of a granted CPU slot
//   RASn       common row strobe
//   CASn       per-plane column strobe
//   WEn        common write enable
//   ADRSEL     1 = CPU address drives VRAM, 0 = display address
//   COLSEL     0 = row half of the address, 1 = column half
//   LATCH      per-plane display-data latch strobe
//   SLOT       current slot index (PLANES = CPU slot)

module vram_slot_seq #(
    parameter int PLANES = 3,
    parameter int PHASES = 4
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic                         BLANKn,
    input  logic                         MODE,
    input  logic                         CPU_REQ,
    input  logic                         CPU_RW,
    input  logic [PLANES-1:0]            CPU_PLANE,
    output logic                         CPU_ACK,
    output logic                         RASn,
    output logic [PLANES-1:0]            CASn,
    output logic                         WEn,
    output logic                         ADRSEL,
    output logic                         COLSEL,
    output logic [PLANES-1:0]            LATCH,
    output logic [$clog2(PLANES+1)-1:0]  SLOT
);

    localparam int SW = $clog2(PLANES + 1);
    localparam int PW = $clog2(PHASES);

    // ST_START holds the counters at slot 0 phase 0 so that the first edge
    // after reset release enters slot 0 phase 0 rather than phase 1.
    typedef enum logic {
        ST_START,
        ST_RUN
    } state_t;

    state_t            state, state_next;
    logic [PW-1:0]     phase, phase_next;
    logic [SW-1:0]     slot, slot_next;

    logic              blank_q, grant_q, rw_q;
    logic [PLANES-1:0] mask_q;

    logic              enter_slot, cpu_next;
    logic              blank_eff, grant_eff, rw_eff;
    logic [PLANES-1:0] mask_eff;
    logic              ras_on, col_on, last_ph;

    logic              rasn_d, wen_d, adrsel_d, colsel_d, ack_d;
    logic [PLANES-1:0] casn_d, latch_d;

    // Next-state logic for the run state and the phase/slot counters.
    always_comb begin
        state_next = ST_RUN;
        phase_next = phase;
        slot_next  = slot;
        if (state == ST_START) begin
            phase_next = '0;
            slot_next  = '0;
        end else if (phase == PW'(PHASES - 1)) begin
            phase_next = '0;
            if (slot == SW'(PLANES)) begin
                slot_next = '0;
            end else begin
                slot_next = slot + SW'(1);
            end
        end else begin
            phase_next = phase + PW'(1);
        end
    end

    // Per-slot samples are taken on the edge entering phase 0. The outputs
    // for that same phase need the freshly sampled values, so they bypass
    // the holding registers on slot entry.
    always_comb begin
        enter_slot = (phase_next == '0);
        cpu_next   = (slot_next == SW'(PLANES));
        blank_eff  = enter_slot ? BLANKn : blank_q;
        grant_eff  = enter_slot ? (cpu_next & CPU_REQ & (MODE | ~BLANKn)) : grant_q;
        rw_eff     = enter_slot ? CPU_RW : rw_q;
        mask_eff   = enter_slot ? CPU_PLANE : mask_q;
    end

    // Strobe values for the phase being entered; registered below so every
    // output is a flop and changes only on the edge entering its phase.
    always_comb begin
        rasn_d   = 1'b1;
        casn_d   = '1;
        wen_d    = 1'b1;
        adrsel_d = 1'b0;
        colsel_d = 1'b0;
        latch_d  = '0;
        ack_d    = 1'b0;
        ras_on   = (phase_next != '0);
        col_on   = (phase_next >= PW'(2));
        last_ph  = (phase_next == PW'(PHASES - 1));
        if (!cpu_next) begin
            // Display slot: always a RAS cycle, so blanking slots still refresh.
            rasn_d   = ~ras_on;
            colsel_d = col_on;
            if (blank_eff) begin
                for (int k = 0; k < PLANES; k++) begin
                    if (slot_next == SW'(k)) begin
                        casn_d[k]  = ~col_on;
                        latch_d[k] = last_ph;
                    end
                end
            end
        end else if (grant_eff) begin
            // Granted CPU slot; an empty mask degenerates to RAS-only but still acks.
            adrsel_d = 1'b1;
            rasn_d   = ~ras_on;
            colsel_d = col_on;
            casn_d   = col_on ? ~mask_eff : '1;
            wen_d    = ~(col_on & ~rw_eff);
            ack_d    = last_ph;
        end
    end

    // Sequencer state, counters and per-slot samples.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= ST_START;
            phase   <= '0;
            slot    <= '0;
            blank_q <= 1'b0;
            grant_q <= 1'b0;
            rw_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            slot    <= slot_next;
            blank_q <= blank_eff;
            grant_q <= grant_eff;
            rw_q    <= rw_eff;
            mask_q  <= mask_eff;
        end
    end

    // Output registers; reset drops all strobes to inactive immediately.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            RASn    <= 1'b1;
            CASn    <= '1;
            WEn     <= 1'b1;
            ADRSEL  <= 1'b0;
            COLSEL  <= 1'b0;
            LATCH   <= '0;
            CPU_ACK <= 1'b0;
            SLOT    <= '0;
        end else begin
            RASn    <= rasn_d;
            CASn    <= casn_d;
            WEn     <= wen_d;
            ADRSEL  <= adrsel_d;
            COLSEL  <= colsel_d;
            LATCH   <= latch_d;
            CPU_ACK <= ack_d;
            SLOT    <= slot_next;
        end
    end

endmodule

// File: tb/tb_vram_slot_seq.sv
// tb_vram_slot_seq
// Drives three sequencer instances (default 3x4, 1x3 and 8x16) from shared
// stimulus and compares every output every cycle against a frame-position
// model: slot and phase come straight from the cycle count since reset.
`timescale 1ns/1ps

module tb_vram_slot_seq;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       BLANKn;
    logic       MODE;
    logic       CPU_REQ;
    logic       CPU_RW;
    logic [7:0] plane;

    logic       a_ack, a_rasn, a_wen, a_adrsel, a_colsel;
    logic [2:0] a_casn, a_latch;
    logic [1:0] a_slot;
    logic       b_ack, b_rasn, b_wen, b_adrsel, b_colsel;
    logic [0:0] b_casn, b_latch;
    logic [0:0] b_slot;
    logic       c_ack, c_rasn, c_wen, c_adrsel, c_colsel;
    logic [7:0] c_casn, c_latch;
    logic [3:0] c_slot;

    logic [24:0] obs [3];

    int planes_c [3] = '{3, 1, 8};
    int phases_c [3] = '{4, 3, 16};

    int         t_m     [3] = '{-1, -1, -1};
    logic       blank_m [3];
    logic       grant_m [3];
    logic       rw_m    [3];
    logic [7:0] mask_m  [3];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    vram_slot_seq #(.PLANES(3), .PHASES(4)) u_a (
        .CLK(CLK), .RSTn(RSTn), .BLANKn(BLANKn), .MODE(MODE),
        .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_PLANE(plane[2:0]),
        .CPU_ACK(a_ack), .RASn(a_rasn), .CASn(a_casn), .WEn(a_wen),
        .ADRSEL(a_adrsel), .COLSEL(a_colsel), .LATCH(a_latch), .SLOT(a_slot)
    );

    vram_slot_seq #(.PLANES(1), .PHASES(3)) u_b (
        .CLK(CLK), .RSTn(RSTn), .BLANKn(BLANKn), .MODE(MODE),
        .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_PLANE(plane[0:0]),
        .CPU_ACK(b_ack), .RASn(b_rasn), .CASn(b_casn), .WEn(b_wen),
        .ADRSEL(b_adrsel), .COLSEL(b_colsel), .LATCH(b_latch), .SLOT(b_slot)
    );

    vram_slot_seq #(.PLANES(8), .PHASES(16)) u_c (
        .CLK(CLK), .RSTn(RSTn), .BLANKn(BLANKn), .MODE(MODE),
        .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_PLANE(plane),
        .CPU_ACK(c_ack), .RASn(c_rasn), .CASn(c_casn), .WEn(c_wen),
        .ADRSEL(c_adrsel), .COLSEL(c_colsel), .LATCH(c_latch), .SLOT(c_slot)
    );

    // Packed view: ack, rasn, wen, adrsel, colsel, slot[3:0], casn[7:0], latch[7:0]
    assign obs[0] = {a_ack, a_rasn, a_wen, a_adrsel, a_colsel, 4'(a_slot), 8'(a_casn), 8'(a_latch)};
    assign obs[1] = {b_ack, b_rasn, b_wen, b_adrsel, b_colsel, 4'(b_slot), 8'(b_casn), 8'(b_latch)};
    assign obs[2] = {c_ack, c_rasn, c_wen, c_adrsel, c_colsel, 4'(c_slot), 8'(c_casn), 8'(c_latch)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] plane_mask(input int i);
        logic [8:0] one;
        one = 9'h1 << planes_c[i];
        return 8'(one - 9'h1);
    endfunction

    // Advance the model of instance i across one clock edge.
    task automatic model_edge(input int i);
        int ph, sl;
        if (!RSTn) begin
            t_m[i]     = -1;
            blank_m[i] = 1'b0;
            grant_m[i] = 1'b0;
            rw_m[i]    = 1'b0;
            mask_m[i]  = 8'h0;
        end else begin
            t_m[i]++;
            ph = t_m[i] % phases_c[i];
            sl = (t_m[i] / phases_c[i]) % (planes_c[i] + 1);
            if (ph == 0) begin
                blank_m[i] = BLANKn;
                if (sl == planes_c[i]) begin
                    grant_m[i] = CPU_REQ & (MODE | ~BLANKn);
                    rw_m[i]    = CPU_RW;
                    mask_m[i]  = plane & plane_mask(i);
                end
            end
        end
    endtask

    // Required outputs of instance i at its current frame position.
    function automatic logic [24:0] expected_out(input int i);
        int ph, sl, np;
        logic [7:0] pm, casn, latch;
        logic ack, rasn, wen, adrsel, colsel;
        pm = plane_mask(i);
        if (t_m[i] < 0) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, pm, 8'h00};
        np = phases_c[i];
        ph = t_m[i] % np;
        sl = (t_m[i] / np) % (planes_c[i] + 1);
        ack = 1'b0; rasn = 1'b1; wen = 1'b1; adrsel = 1'b0; colsel = 1'b0;
        casn = pm; latch = 8'h00;
        if (sl < planes_c[i]) begin
            rasn   = (ph == 0);
            colsel = (ph >= 2);
            if (blank_m[i]) begin
                casn[sl]  = (ph < 2);
                latch[sl] = (ph == np - 1);
            end
        end else if (grant_m[i]) begin
            adrsel = 1'b1;
            rasn   = (ph == 0);
            colsel = (ph >= 2);
            if (ph >= 2) casn = pm & ~mask_m[i];
            wen    = !(ph >= 2 && !rw_m[i]);
            ack    = (ph == np - 1);
        end
        return {ack, rasn, wen, adrsel, colsel, 4'(sl), casn, latch};
    endfunction

    task automatic applyStimulus();
        @(posedge CLK);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("inst%0d_out_t%0d", i, t_m[i]), 32'(obs[i]), 32'(expected_out(i)));
    endtask

    initial begin
        int n, acks, wen_low, ras_low, cas_on, latch_on;
        int last_wrap_b, last_wrap_c, frame_b, frame_c, max_b, max_c;
        logic [3:0] prev_b, prev_c;

        RSTn = 1'b0; BLANKn = 1'b1; MODE = 1'b0; CPU_REQ = 1'b0; CPU_RW = 1'b1; plane = 8'h00;

        // Reset held for 5 cycles, then one idle frame.
        repeat (5) applyStimulus();
        RSTn = 1'b1;
        repeat (16) applyStimulus();

        // MODE=0 with active display: request must stay blocked.
        CPU_REQ = 1'b1; plane = 8'b010; CPU_RW = 1'b0;
        acks = 0; wen_low = 0;
        repeat (48) begin
            applyStimulus();
            if (a_ack) acks++;
            if (!a_wen) wen_low++;
        end
        check("mode0_no_ack", acks, 0);
        check("mode0_wen_idle", wen_low, 0);

        // Blanking opens the CPU slot.
        BLANKn = 1'b0;
        n = 0;
        do begin applyStimulus(); n++; end while (!a_ack && n < 40);
        check("mode0_blank_ack_latency", n, 16);
        check("mode0_blank_cas", 32'(a_casn), 32'b101);
        check("mode0_blank_wen", 32'(a_wen), 0);
        check("mode0_blank_adrsel", 32'(a_adrsel), 1);
        CPU_REQ = 1'b0; BLANKn = 1'b1;

        // MODE=1 read requested at slot 3 phase 1.
        MODE = 1'b1; CPU_RW = 1'b1; plane = 8'b101;
        n = 0;
        while (t_m[0] % 16 != 13 && n < 20) begin applyStimulus(); n++; end
        CPU_REQ = 1'b1;
        n = 0;
        do begin applyStimulus(); n++; end while (!a_ack && n < 40);
        check("mode1_read_latency", n, 18);
        check("mode1_read_cas", 32'(a_casn), 32'b010);
        check("mode1_read_wen", 32'(a_wen), 1);
        CPU_REQ = 1'b0; MODE = 1'b0;

        // Blanking across one full frame: refresh only.
        BLANKn = 1'b0;
        n = 0;
        while (t_m[0] % 16 != 15 && n < 20) begin applyStimulus(); n++; end
        ras_low = 0; cas_on = 0; latch_on = 0;
        repeat (16) begin
            applyStimulus();
            if (!a_rasn) ras_low++;
            if (a_casn != 3'b111) cas_on++;
            if (a_latch != 3'b000) latch_on++;
        end
        check("refresh_ras_cycles", ras_low, 9);
        check("refresh_no_cas", cas_on, 0);
        check("refresh_no_latch", latch_on, 0);
        BLANKn = 1'b1;

        // Reset pulsed during CPU-slot phase 2 of a write.
        MODE = 1'b1; CPU_REQ = 1'b1; CPU_RW = 1'b0; plane = 8'b111;
        n = 0;
        do begin applyStimulus(); n++; end while (!(t_m[0] % 16 == 14 && !a_wen) && n < 48);
        check("midwrite_reached_wen", 32'(a_wen), 0);
        RSTn = 1'b0;
        #1;
        check("midwrite_async_reset", 32'(obs[0]), {7'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h07, 8'h00});
        CPU_REQ = 1'b0; MODE = 1'b0;
        repeat (2) applyStimulus();
        RSTn = 1'b1;
        applyStimulus();
        check("restart_slot0", 32'(a_slot), 0);

        // Randomised traffic with a well-behaved requester.
        for (int k = 0; k < 1500; k++) begin
            applyStimulus();
            if (CPU_REQ && a_ack) CPU_REQ = 1'b0;
            else if (CPU_REQ && $urandom_range(0, 63) == 0) CPU_REQ = 1'b0;
            else if (!CPU_REQ && $urandom_range(0, 7) == 0) begin
                CPU_REQ = 1'b1;
                CPU_RW  = 1'($urandom);
                plane   = 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) BLANKn = ~BLANKn;
            if ($urandom_range(0, 199) == 0) MODE = ~MODE;
        end

        // Frame length and slot wrap for the small and large instances.
        CPU_REQ = 1'b0;
        last_wrap_b = -1; last_wrap_c = -1; frame_b = 0; frame_c = 0; max_b = 0; max_c = 0;
        prev_b = obs[1][19:16]; prev_c = obs[2][19:16];
        for (int k = 0; k < 400; k++) begin
            applyStimulus();
            if (int'(obs[1][19:16]) > max_b) max_b = int'(obs[1][19:16]);
            if (int'(obs[2][19:16]) > max_c) max_c = int'(obs[2][19:16]);
            if (prev_b != 0 && obs[1][19:16] == 0) begin
                if (last_wrap_b >= 0 && frame_b == 0) frame_b = k - last_wrap_b;
                last_wrap_b = k;
            end
            if (prev_c != 0 && obs[2][19:16] == 0) begin
                if (last_wrap_c >= 0 && frame_c == 0) frame_c = k - last_wrap_c;
                last_wrap_c = k;
            end
            prev_b = obs[1][19:16]; prev_c = obs[2][19:16];
        end
        check("sweep_small_frame", frame_b, 6);
        check("sweep_large_frame", frame_c, 144);
        check("sweep_small_max_slot", max_b, 1);
        check("sweep_large_max_slot", max_c, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
